// File: rtl/obi_mem_responder_if.sv
// OBI data-bus bundle between an initiator (core/arbiter) and a memory responder.
// Handshake: a transfer is taken on the cycle req && gnt; rvalid is pulsed once per taken transfer, in order, with no backpressure.
interface obi_mem_responder_if;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_mem_responder.sv
// Single-port OBI memory responder: byte-enabled SRAM array behind a fixed-latency,
// in-order response pipeline with an outstanding-transfer cap and optional random stalls.
module obi_mem_responder #(
    parameter int          DEPTH_WORDS     = 16384,
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int          RSP_LATENCY     = 1,
    parameter int          MAX_OUTSTANDING = 4,
    parameter bit          STALL_EN        = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    obi_mem_responder_if.slave  bus,
    output logic [3:0]          outstanding_o
);
    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH32   = 32'(DEPTH_WORDS);
    localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [31:0]            mem_q [DEPTH_WORDS];
    logic [15:0]            lfsr_q, lfsr_d;
    logic [RSP_LATENCY-1:0] vld_q, vld_d;
    logic [RSP_LATENCY-1:0] err_q, err_d;
    logic [31:0]            data_q [RSP_LATENCY];
    logic [31:0]            data_d [RSP_LATENCY];
    logic [3:0]             outstanding_q, outstanding_d;

    logic [31:0]            offset;
    logic [IDX_W-1:0]       mem_idx;
    logic                   in_range;
    logic                   rsp_out;
    logic                   gnt;
    logic                   wr_en;

    always_comb begin
        offset   = (bus.addr - ADDR_BASE) >> 2;
        mem_idx  = offset[IDX_W-1:0];
        in_range = (bus.addr >= ADDR_BASE) && (offset < DEPTH32);
        rsp_out  = vld_q[RSP_LATENCY-1];
        // A response leaving this cycle frees its slot, so grants keep pace with responses.
        gnt      = bus.req & ~rst_i
                 & ((outstanding_q - {3'b000, rsp_out}) < MAX_OUT)
                 & ~(STALL_EN & lfsr_q[0]);
        wr_en    = gnt & bus.we & in_range;
    end

    always_comb begin
        lfsr_d        = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        vld_d         = '0;
        err_d         = '0;
        vld_d[0]      = gnt;
        err_d[0]      = gnt & ~in_range;
        data_d[0]     = (gnt & ~bus.we & in_range) ? mem_q[mem_idx] : 32'h0;
        for (int i = 1; i < RSP_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
        end
        outstanding_d = outstanding_q + {3'b000, gnt} - {3'b000, rsp_out};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q        <= LFSR_SEED;
            vld_q         <= '0;
            err_q         <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            lfsr_q        <= lfsr_d;
            vld_q         <= vld_d;
            err_q         <= err_d;
            outstanding_q <= outstanding_d;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.be[n]) begin
                    mem_q[mem_idx][8*n +: 8] <= bus.wdata[8*n +: 8];
                end
            end
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rvalid    = rsp_out;
    assign bus.rdata     = data_q[RSP_LATENCY-1];
    assign bus.err       = err_q[RSP_LATENCY-1];
    assign outstanding_o = outstanding_q;

endmodule
